// File: rtl/chacha20_stream_xor.sv
// chacha20_stream_xor: XORs a 32-bit plaintext word stream with ChaCha20 keystream blocks fetched from an external core.
// Ports: clock, reset (synchronous, active-high); load/key/nonce start or restart a session;
// in_valid/in_ready/in_data carry plaintext; out_valid/out_ready/out_data carry ciphertext;
// core_start/core_key/core_nonce/core_index request one 512-bit block; core_done/core_out return it.
module chacha20_stream_xor #(
    parameter logic [63:0] COUNTER_START = 64'd0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [255:0] key,
    input  logic [63:0]  nonce,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         core_start,
    output logic [255:0] core_key,
    output logic [63:0]  core_nonce,
    output logic [63:0]  core_index,
    input  logic         core_done,
    input  logic [511:0] core_out
);
    localparam logic [2:0] IDLE = 3'd0, GEN = 3'd1, WAIT = 3'd2, XOR = 3'd3, DRAIN = 3'd4;
    logic [2:0]   state;
    logic [3:0]   ptr;
    logic [511:0] buffer;
    logic         in_fire;
    // load wins over a coincident input word and suppresses a stale block request
    always_comb begin
        in_ready   = (state == XOR) && (!out_valid || out_ready) && !load;
        in_fire    = in_valid && in_ready;
        core_start = (state == GEN) && !load;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            core_index <= COUNTER_START;
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            core_key   <= '0;
            core_nonce <= '0;
        end else begin
            // the buffer shifts left per consumed word, so the current word is always the top 32 bits
            if (in_fire) begin
                out_data  <= in_data ^ buffer[511:480];
                out_valid <= 1'b1;
                ptr       <= ptr + 4'd1;
                buffer    <= {buffer[479:0], 32'd0};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // a load during WAIT/DRAIN must still swallow the block already requested from the core
            if (load) begin
                core_key   <= key;
                core_nonce <= nonce;
                core_index <= COUNTER_START;
                state      <= (state == WAIT || state == DRAIN) ? DRAIN : GEN;
            end else if (state == GEN) begin
                state <= WAIT;
            end else if (state == WAIT && core_done) begin
                buffer     <= core_out;
                ptr        <= '0;
                core_index <= core_index + 64'd1;
                state      <= XOR;
            end else if (state == DRAIN && core_done) begin
                state <= GEN;
            end else if (in_fire && ptr == 4'd15) begin
                state <= GEN;
            end
        end
    end
endmodule
